ucomb_seq: RTL and testbench

//  Configuration and sweep sequencer for the universal-gate test harness (ucomb_full).

---
 rtl/ucomb_pkg.sv | 44 ++++
 rtl/ucomb_misr.sv | 39 +++
 rtl/ucomb_seq.sv | 157 +++++++++++++++
 tb/tb_ucomb_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucomb_pkg.sv
// ============================================================================
// ucomb_pkg : shared opcodes, FSM encoding and signature defaults for
//             the universal-gate harness sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package ucomb_pkg;

  localparam int DUT_IN_W  = 19;
  localparam int DUT_OUT_W = 12;
  localparam int PAYLOAD_W = 17;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_SEL  = 2'd1;
  localparam logic [1:0] OP_FUNC = 2'd2;
  localparam logic [1:0] OP_PIN  = 2'd3;

  localparam logic [15:0] SIG_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] SIG_INIT_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_SEL  = 3'd1,
    S_WR_FUNC = 3'd2,
    S_WR_PIN  = 3'd3,
    S_SWEEP   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // One MISR step: Galois shift with polynomial feedback, harness output folded into the low bits
  function automatic logic [15:0] misr_step(
    input logic [15:0]          cur,
    input logic [15:0]          poly,
    input logic [DUT_OUT_W-1:0] data
  );
    logic [15:0] w_fb;
    w_fb = cur[15] ? poly : 16'h0000;
    return {cur[14:0], 1'b0} ^ w_fb ^ {4'h0, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ucomb_misr.sv
// ============================================================================
// ucomb_misr : 16-bit multiple-input signature register over the 12-bit
//              harness output; seeded on load, stepped on enable
// Revision   : 1.0
// ============================================================================
`default_nettype none

module ucomb_misr
  import ucomb_pkg::*;
#(
  parameter logic [15:0] POLY = SIG_POLY_DEFAULT,
  parameter logic [15:0] INIT = SIG_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 enable,
  input  logic [DUT_OUT_W-1:0] data_in,
  output logic [15:0]          sig
);

  logic [15:0] r_sig;

  // load wins over enable so a new request always starts from the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= INIT;
    end else if (load) begin
      r_sig <= INIT;
    end else if (enable) begin
      r_sig <= misr_step(r_sig, POLY, data_in);
    end
  end

  assign sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/ucomb_seq.sv
// ============================================================================
// ucomb_seq : configuration and sweep sequencer for the universal-gate harness;
//             three config writes, N sweep vectors, signature of the outputs
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ucomb_seq
  import ucomb_pkg::*;
#(
  parameter int          CNT_W    = 12,
  parameter logic [15:0] SIG_POLY = SIG_POLY_DEFAULT,
  parameter logic [15:0] SIG_INIT = SIG_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_sel,
  input  logic [15:0]          req_func,
  input  logic [3:0]           req_pin,
  input  logic [CNT_W-1:0]     req_count,
  input  logic                 abort,
  output logic [DUT_IN_W-1:0]  dut_in,
  input  logic [DUT_OUT_W-1:0] dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sig
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_sel;
  logic [15:0]         r_func;
  logic [3:0]          r_pin;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    w_idx_next;
  logic [CNT_W-1:0]    w_idx_inc;
  logic [DUT_IN_W-1:0] r_dut_in;
  logic [DUT_IN_W-1:0] w_dut_in_next;
  logic                w_idle;
  logic                w_accept;
  logic                w_abort;
  logic                w_last;
  logic                w_misr_en;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = req_valid & w_idle;
  assign w_abort   = abort & ~w_idle;
  assign w_idx_inc = r_idx + c_one;
  assign w_last    = (r_idx == (r_count - c_one));

  // dut_in is registered, so the bus word for the next state is chosen here
  always_comb begin
    w_state_next  = r_state;
    w_dut_in_next = '0;
    w_idx_next    = r_idx;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next  = S_WR_SEL;
          w_dut_in_next = {15'b0, req_sel, OP_SEL};
          w_idx_next    = '0;
        end
      end
      S_WR_SEL: begin
        w_state_next  = S_WR_FUNC;
        w_dut_in_next = {1'b0, r_func, OP_FUNC};
      end
      S_WR_FUNC: begin
        w_state_next  = S_WR_PIN;
        w_dut_in_next = {13'b0, r_pin, OP_PIN};
      end
      S_WR_PIN: begin
        if (r_count == '0) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next  = S_SWEEP;
          w_dut_in_next = {PAYLOAD_W'(r_idx), OP_NOP};
        end
      end
      S_SWEEP: begin
        w_idx_next = w_idx_inc;
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_dut_in_next = {PAYLOAD_W'(w_idx_inc), OP_NOP};
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_next  = S_IDLE;
      w_dut_in_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dut_in <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_dut_in <= w_dut_in_next;
      r_idx    <= w_idx_next;
    end
  end

  // Request fields are captured only on accept; req_valid while busy is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= '0;
      r_func  <= '0;
      r_pin   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sel   <= req_sel;
      r_func  <= req_func;
      r_pin   <= req_pin;
      r_count <= req_count;
    end
  end

  // An aborted sweep cycle leaves the signature untouched
  assign w_misr_en = (r_state == S_SWEEP) & ~abort;

  ucomb_misr #(
    .POLY (SIG_POLY),
    .INIT (SIG_INIT)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_accept),
    .enable  (w_misr_en),
    .data_in (dut_out),
    .sig     (sig)
  );

  assign req_ready = w_idle;
  assign busy      = ~w_idle;
  assign done      = (r_state == S_DONE);
  assign dut_in    = r_dut_in;

endmodule

`default_nettype wire

// File: tb/tb_ucomb_seq.sv
// ============================================================================
// tb_ucomb_seq : self-checking bench for ucomb_seq with a behavioural harness
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_ucomb_seq;
  import ucomb_pkg::*;

  localparam int CNT_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_sel = '0;
  logic [15:0]       req_func = '0;
  logic [3:0]        req_pin = '0;
  logic [CNT_W-1:0]  req_count = '0;
  logic              abort = 1'b0;
  logic [18:0]       dut_in;
  logic [11:0]       dut_out;
  logic              busy;
  logic              done;
  logic [15:0]       sig;

  int          n_pass = 0;
  int          n_total = 0;
  logic [18:0] exp_q[$];
  bit          tie_zero = 1'b1;

  always #5 clk = ~clk;

  ucomb_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_func  (req_func),
    .req_pin   (req_pin),
    .req_count (req_count),
    .abort     (abort),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .sig       (sig)
  );

  // Behavioural stand-in for the gate harness: config registers plus a combinational output
  function automatic logic [11:0] harness_f(input logic [16:0] p, input logic [1:0] s,
                                            input logic [15:0] f, input logic [3:0] pn);
    return {p[7:0] ^ f[15:8], pn ^ f[3:0]} ^ {p[16:13], 6'b0, s};
  endfunction

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [11:0] d);
    logic [15:0] nxt;
    nxt = {s[14:0], 1'b0};
    if (s[15]) nxt = nxt ^ 16'h1021;
    return nxt ^ {4'h0, d};
  endfunction

  logic [1:0]  h_sel;
  logic [15:0] h_func;
  logic [3:0]  h_pin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sel <= '0; h_func <= '0; h_pin <= '0;
    end else begin
      case (dut_in[1:0])
        2'd1: h_sel  <= dut_in[3:2];
        2'd2: h_func <= dut_in[17:2];
        2'd3: h_pin  <= dut_in[5:2];
        default: ;
      endcase
    end
  end

  assign dut_out = tie_zero ? 12'h000 : harness_f(dut_in[18:2], h_sel, h_func, h_pin);

  // Called at a negedge; returns #1 after the accepting edge
  task automatic issue(input logic [1:0] s, input logic [15:0] f, input logic [3:0] p,
                       input int n);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_total++;
      $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, w);
    end
    req_sel = s; req_func = f; req_pin = p; req_count = CNT_W'(n);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] s, input logic [15:0] f, input logic [3:0] p,
                         input int n, input string name);
    logic [15:0] ref_sig;
    logic [18:0] e;
    logic [16:0] v;
    int k;
    ref_sig = 16'hFFFF;
    exp_q.push_back({15'b0, s, 2'd1});
    exp_q.push_back({1'b0, f, 2'd2});
    exp_q.push_back({13'b0, p, 2'd3});
    for (int i = 0; i < n; i++) begin
      v = 17'(i);
      exp_q.push_back({v, 2'd0});
      ref_sig = misr_ref(ref_sig, tie_zero ? 12'h000 : harness_f(v, s, f, p));
    end
    issue(s, f, p, n);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      k++;
      n_total++;
      if (dut_in !== e || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s_cycle%0d: dut_in=%05h done=%b busy=%b, required dut_in=%05h done=0 busy=1",
                 name, k, dut_in, done, busy, e);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || dut_in !== 19'h0 || sig !== ref_sig)
      $display("FAIL %s_done: done=%b dut_in=%05h sig=%04h, required done=1 dut_in=00000 sig=%04h",
               name, done, dut_in, sig, ref_sig);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || sig !== ref_sig)
      $display("FAIL %s_after: done=%b busy=%b ready=%b sig=%04h, required 0/0/1 sig=%04h",
               name, done, busy, req_ready, sig, ref_sig);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (dut_in !== 19'h0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || sig !== 16'hFFFF)
      $display("FAIL reset_values: dut_in=%05h busy=%b done=%b ready=%b sig=%04h, required 00000/0/0/1/FFFF",
               dut_in, busy, done, req_ready, sig);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_config_only;
    tie_zero = 1'b1;
    run_req(2'd2, 16'hA5C3, 4'd9, 0, "config_only");
  endtask

  task automatic test_sweep_zero;
    tie_zero = 1'b1;
    run_req(2'd2, 16'hA5C3, 4'd9, 4, "sweep4_zero");
  endtask

  task automatic test_sweep_harness;
    tie_zero = 1'b0;
    run_req(2'd1, 16'h6B2D, 4'd5, 1, "sweep1");
    run_req(2'd3, 16'hC0DE, 4'hE, 256, "sweep256");
  endtask

  task automatic test_abort;
    tie_zero = 1'b0;
    issue(2'd2, 16'hA5C3, 4'd9, 4);
    @(negedge clk);
    n_total++;
    if (dut_in !== 19'h00009) $display("FAIL abort_sel: dut_in=%05h, required 00009", dut_in);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (dut_in !== {1'b0, 16'hA5C3, 2'd2}) $display("FAIL abort_func: dut_in=%05h, required %05h", dut_in, {1'b0, 16'hA5C3, 2'd2});
    else n_pass++;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    n_total++;
    if (dut_in !== 19'h0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL abort_idle: dut_in=%05h busy=%b done=%b ready=%b, required 00000/0/0/1",
               dut_in, busy, done, req_ready);
    else n_pass++;
    run_req(2'd3, 16'h0F0F, 4'h6, 2, "after_abort");
  endtask

  task automatic test_abort_in_idle;
    tie_zero = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL abort_in_idle: busy=%b ready=%b, required 0/1", busy, req_ready);
    else n_pass++;
    run_req(2'd0, 16'h8001, 4'h3, 3, "abort_held_at_accept");
  endtask

  task automatic test_reset_mid_sweep;
    tie_zero = 1'b0;
    issue(2'd1, 16'h1234, 4'd5, 8);
    repeat (6) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || dut_in !== {17'd2, 2'd0})
      $display("FAIL reset_mid_pre: busy=%b dut_in=%05h, required 1/%05h", busy, dut_in, {17'd2, 2'd0});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (dut_in !== 19'h0 || busy !== 1'b0 || done !== 1'b0 || sig !== 16'hFFFF)
      $display("FAIL reset_mid: dut_in=%05h busy=%b done=%b sig=%04h, required 00000/0/0/FFFF",
               dut_in, busy, done, sig);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 19'h0)
      $display("FAIL reset_mid_after: busy=%b done=%b dut_in=%05h, required 0/0/00000", busy, done, dut_in);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int sel_cnt, done_cnt, rdy_cnt, first_sel, last_sel, last_done;
    sel_cnt = 0; done_cnt = 0; rdy_cnt = 0; first_sel = -1; last_sel = -1; last_done = -1;
    tie_zero = 1'b0;
    req_sel = 2'd1; req_func = 16'h3C3C; req_pin = 4'd7; req_count = CNT_W'(2);
    req_valid = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (dut_in[1:0] == 2'd1) begin
        sel_cnt++;
        if (first_sel < 0) first_sel = i;
        last_sel = i;
      end
      if (done === 1'b1) begin
        done_cnt++;
        last_done = i;
      end
      if (req_ready === 1'b1) rdy_cnt++;
    end
    req_valid = 1'b0;
    n_total++;
    if (sel_cnt != 3 || done_cnt != 3 || rdy_cnt != 3)
      $display("FAIL b2b_counts: sel=%0d done=%0d ready=%0d, required 3/3/3", sel_cnt, done_cnt, rdy_cnt);
    else n_pass++;
    n_total++;
    if (first_sel != 1 || last_sel != 15 || last_done != 20)
      $display("FAIL b2b_spacing: first_sel=%0d last_sel=%0d last_done=%0d, required 1/15/20",
               first_sel, last_sel, last_done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1 || dut_in !== 19'h0)
      $display("FAIL b2b_release: ready=%b dut_in=%05h, required 1/00000", req_ready, dut_in);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_config_only();
    test_sweep_zero();
    test_sweep_harness();
    test_abort();
    test_abort_in_idle();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
